// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit core.
// Drives ALU controls, write strobes and the program-memory fetch.
module control_unit (
    input  logic       clk,
    input  logic       rst_n,
    output logic       imem_req,
    output logic [7:0] imem_addr,
    input  logic       imem_ack,
    input  logic [7:0] imem_data,
    input  logic       cy,
    output logic [3:0] alu_op,
    output logic       alu_ci,
    output logic       b_sel,
    output logic [7:0] imm,
    output logic [3:0] rf_idx,
    output logic       acc_we,
    output logic       rf_we,
    output logic       cy_ce,
    output logic [7:0] pc,
    output logic       halted
);

    typedef enum logic [1:0] {
        FETCH,
        FETCH_OP,
        EXEC,
        HALT
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [7:0] ir;
    logic [7:0] tgt;
    logic [3:0] op;
    logic       fetching;
    logic       two_byte;
    logic       take;

    assign op        = ir[7:4];
    assign imm       = {4'h0, ir[3:0]};
    assign rf_idx    = ir[3:0];
    assign imem_addr = pc;
    assign fetching  = (state == FETCH) || (state == FETCH_OP);
    // Gating with rst_n drops the request the instant reset asserts.
    assign imem_req  = rst_n && fetching;
    assign two_byte  = (imem_data[7:4] >= 4'h9) && (imem_data[7:4] <= 4'hB);
    assign take      = (op == 4'h9) || ((op == 4'hA) && cy) ||
                       ((op == 4'hB) && !cy);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            pc    <= 8'h00;
            ir    <= 8'hE0;
            tgt   <= 8'h00;
        end else begin
            state <= state_nx;
            unique case (state)
                FETCH: begin
                    if (imem_ack) begin
                        ir <= imem_data;
                        pc <= pc + 8'd1;
                    end
                end
                FETCH_OP: begin
                    if (imem_ack) begin
                        tgt <= imem_data;
                        pc  <= pc + 8'd1;
                    end
                end
                EXEC: begin
                    if (take) pc <= tgt;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            FETCH: begin
                if (imem_ack) state_nx = two_byte ? FETCH_OP : EXEC;
            end
            FETCH_OP: begin
                if (imem_ack) state_nx = EXEC;
            end
            EXEC:    state_nx = (op == 4'hF) ? HALT : FETCH;
            default: state_nx = HALT;
        endcase
    end

    always_comb begin
        alu_op = op;
        alu_ci = 1'b0;
        b_sel  = 1'b0;
        acc_we = 1'b0;
        rf_we  = 1'b0;
        cy_ce  = 1'b0;
        halted = (state == HALT);
        unique case (op)
            4'h0, 4'h1: alu_ci = cy;
            4'h6:       alu_op = 4'hF;
            4'h8: begin
                alu_op = 4'hF;
                b_sel  = 1'b1;
            end
            4'hC:       alu_op = 4'hF;
            4'hD: begin
                alu_op = 4'hF;
                alu_ci = 1'b1;
            end
            default: ;
        endcase
        if (state == EXEC) begin
            unique case (op)
                4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
                    acc_we = 1'b1;
                    cy_ce  = 1'b1;
                end
                4'h6, 4'h8:  acc_we = 1'b1;
                4'h7:        rf_we  = 1'b1;
                4'hC, 4'hD:  cy_ce  = 1'b1;
                4'hF:        halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: instruction-level reference model checked
// every cycle, plus directed programs with hand-computed expectations.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       imem_ack = 1'b0;
    logic       cy = 1'b0;
    logic [7:0] imem_data;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic [3:0] alu_op;
    logic       alu_ci;
    logic       b_sel;
    logic [7:0] imm;
    logic [3:0] rf_idx;
    logic       acc_we;
    logic       rf_we;
    logic       cy_ce;
    logic [7:0] pc;
    logic       halted;

    logic [7:0] mem [256];

    int errors = 0;
    int checks = 0;

    control_unit dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .cy(cy), .alu_op(alu_op), .alu_ci(alu_ci),
        .b_sel(b_sel), .imm(imm), .rf_idx(rf_idx),
        .acc_we(acc_we), .rf_we(rf_we), .cy_ce(cy_ce),
        .pc(pc), .halted(halted)
    );

    assign imem_data = mem[imem_addr];

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: whole instructions, counted in bytes fetched.
    logic [7:0] m_pc;
    logic [7:0] m_ir;
    logic [7:0] m_tgt;
    int         m_cnt;
    bit         m_exec;
    bit         m_halt;

    function automatic int ilen(input logic [3:0] o);
        return (o >= 4'h9 && o <= 4'hB) ? 2 : 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [3:0] o;
        if (!rst_n) begin
            m_pc   = 8'h00;
            m_ir   = 8'hE0;
            m_tgt  = 8'h00;
            m_cnt  = 0;
            m_exec = 0;
            m_halt = 0;
        end else if (!m_halt) begin
            if (!m_exec) begin
                if (imem_ack) begin
                    if (m_cnt == 0) m_ir = mem[m_pc];
                    else m_tgt = mem[m_pc];
                    m_pc = m_pc + 8'd1;
                    m_cnt++;
                    if (m_cnt == ilen(m_ir[7:4])) m_exec = 1;
                end
            end else begin
                o = m_ir[7:4];
                if (o == 4'h9 || (o == 4'hA && cy) || (o == 4'hB && !cy))
                    m_pc = m_tgt;
                if (o == 4'hF) m_halt = 1;
                m_exec = 0;
                m_cnt  = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] o;
        logic       ex;
        logic       rq;
        o  = m_ir[7:4];
        ex = rst_n && m_exec;
        rq = rst_n && !m_halt && !m_exec;
        chk("req", imem_req, rq);
        if (rq) chk("addr", imem_addr, m_pc);
        chk("pc", pc, m_pc);
        chk("alu_op", alu_op,
            (o == 4'h6 || o == 4'h8 || o == 4'hC || o == 4'hD) ? 4'hF : o);
        chk("alu_ci", alu_ci, (o <= 4'h1) ? cy : (o == 4'hD));
        chk("b_sel", b_sel, o == 4'h8);
        chk("imm", imm, {4'h0, m_ir[3:0]});
        chk("rf_idx", rf_idx, m_ir[3:0]);
        chk("acc_we", acc_we, ex && (o <= 4'h6 || o == 4'h8));
        chk("cy_ce", cy_ce, ex && (o <= 4'h5 || o == 4'hC || o == 4'hD));
        chk("rf_we", rf_we, ex && o == 4'h7);
        chk("halted", halted, m_halt || (ex && o == 4'hF));
    end

    task automatic reset_on();
        @(negedge clk);
        #2 rst_n = 1'b0;
        imem_ack = 1'b1;
        cy = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'hE0;
    endtask

    task automatic reset_off();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic jump_case(input logic [7:0] opc, input logic c,
                             input logic [7:0] exp_pc, input string nm);
        reset_on();
        mem[0] = opc;
        mem[1] = 8'h40;
        cy = c;
        reset_off();
        repeat (3) @(negedge clk);
        chk(nm, pc, exp_pc);
        chk({nm, "_addr"}, imem_addr, exp_pc);
    endtask

    initial begin
        // Straight-line program LDI #5, MOV R2,A, HLT.
        reset_on();
        mem[0] = 8'h85;
        mem[1] = 8'h72;
        mem[2] = 8'hF0;
        @(negedge clk);
        chk("rst_pc", pc, 8'h00);
        chk("rst_alu_op", alu_op, 4'hE);
        chk("rst_imm", imm, 8'h00);
        chk("rst_req", imem_req, 1'b0);
        reset_off();
        #1 chk("first_req", imem_req, 1'b1);
        @(negedge clk);
        chk("ldi_acc_we", acc_we, 1'b1);
        chk("ldi_imm", imm, 8'h05);
        chk("ldi_b_sel", b_sel, 1'b1);
        @(negedge clk);
        chk("ldi_acc_we_off", acc_we, 1'b0);
        @(negedge clk);
        chk("mov_rf_we", rf_we, 1'b1);
        chk("mov_rf_idx", rf_idx, 4'h2);
        repeat (2) @(negedge clk);
        chk("hlt_halted6", halted, 1'b1);
        @(negedge clk);
        chk("hlt_halted7", halted, 1'b1);
        chk("hlt_req", imem_req, 1'b0);
        repeat (3) @(negedge clk);
        chk("hlt_stay_req", imem_req, 1'b0);

        // ADD R1 with carry set.
        reset_on();
        mem[0] = 8'h01;
        cy = 1'b1;
        reset_off();
        @(negedge clk);
        chk("add_op", alu_op, 4'h0);
        chk("add_ci", alu_ci, 1'b1);
        chk("add_bsel", b_sel, 1'b0);
        chk("add_idx", rf_idx, 4'h1);
        chk("add_acc", acc_we, 1'b1);
        chk("add_cyce", cy_ce, 1'b1);
        @(negedge clk);
        chk("add_acc_off", acc_we, 1'b0);
        chk("add_cyce_off", cy_ce, 1'b0);

        jump_case(8'hA0, 1'b0, 8'h02, "jc_nt");
        jump_case(8'hA0, 1'b1, 8'h40, "jc_t");
        jump_case(8'hB0, 1'b0, 8'h40, "jnc_t");
        jump_case(8'hB0, 1'b1, 8'h02, "jnc_nt");

        // Wait states: ack low for three cycles.
        reset_on();
        mem[0] = 8'h85;
        imem_ack = 1'b0;
        reset_off();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ws_req", imem_req, 1'b1);
            chk("ws_addr", imem_addr, 8'h00);
            chk("ws_pc", pc, 8'h00);
            chk("ws_acc", acc_we, 1'b0);
        end
        imem_ack = 1'b1;
        @(negedge clk);
        chk("ws_acc_on", acc_we, 1'b1);
        chk("ws_pc_inc", pc, 8'h01);

        // JMP 0xFF, NOP there wraps pc to 0x00.
        reset_on();
        mem[0] = 8'h90;
        mem[1] = 8'hFF;
        reset_off();
        repeat (3) @(negedge clk);
        chk("wrap_pc_ff", pc, 8'hFF);
        @(negedge clk);
        chk("wrap_pc_00", pc, 8'h00);
        @(negedge clk);
        chk("wrap_addr", imem_addr, 8'h00);

        // Reset during EXEC of SETC.
        reset_on();
        mem[0] = 8'hD0;
        reset_off();
        @(negedge clk);
        chk("setc_cyce", cy_ce, 1'b1);
        chk("setc_ci", alu_ci, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_cyce", cy_ce, 1'b0);
        chk("mid_req", imem_req, 1'b0);
        chk("mid_pc", pc, 8'h00);
        chk("mid_op", alu_op, 4'hE);
        chk("mid_ci", alu_ci, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 chk("restart_req", imem_req, 1'b1);
        chk("restart_addr", imem_addr, 8'h00);

        // Random programs with random wait states and carry.
        for (int ep = 0; ep < 6; ep++) begin
            reset_on();
            for (int i = 0; i < 256; i++) begin
                logic [7:0] b;
                b = 8'($urandom);
                if (b[7:4] == 4'hF && ($urandom % 16) != 0) b[7:4] = 4'hE;
                mem[i] = b;
            end
            reset_off();
            repeat (400) begin
                @(posedge clk);
                #2;
                imem_ack = ($urandom % 4) != 0;
                cy = 1'($urandom % 2);
            end
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
